// File: rtl/tdc_interval_counter_mc.sv
// Multi-channel coarse TDC interval counter. A shared start edge arms every channel,
// and per-channel stop edges end the interval. Results merge round-robin into one valid/ready stream.
module tdc_interval_counter_mc #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 12,
   parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       edge_sel,
   input  logic             ref_in,
   input  logic [N_CH-1:0]  sig_in,
   input  logic             clr_err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CH_W-1:0]  out_ch,
   output logic [CNT_W-1:0] out_time,
   output logic             out_ovf,
   output logic [N_CH-1:0]  busy,
   output logic [N_CH-1:0]  drop_err,
   output logic [N_CH-1:0]  lost_err
);

   typedef enum logic {IDLE = 1'b0, COUNTING = 1'b1} ch_state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic                        ref_in_q;
   logic [N_CH-1:0]             sig_in_q;
   ch_state_e                   state_q [N_CH];
   ch_state_e                   state_d [N_CH];
   logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic [N_CH-1:0]             pend_q, pend_d;
   logic [N_CH-1:0][CNT_W-1:0]  pend_time_q, pend_time_d;
   logic [N_CH-1:0]             pend_ovf_q, pend_ovf_d;
   logic                        out_valid_q, out_valid_d;
   logic [CH_W-1:0]             out_ch_q, out_ch_d;
   logic [CNT_W-1:0]            out_time_q, out_time_d;
   logic                        out_ovf_q, out_ovf_d;
   logic [CH_W-1:0]             rr_ptr_q, rr_ptr_d;
   logic [N_CH-1:0]             drop_err_q, drop_err_d;
   logic [N_CH-1:0]             lost_err_q, lost_err_d;

   logic                        start_edge;
   logic [N_CH-1:0]             stop_edge;
   logic [N_CH-1:0]             cap_vld;
   logic [N_CH-1:0]             cap_ovf;
   logic [N_CH-1:0]             lost_set;
   logic [N_CH-1:0]             drop_set;
   logic                        out_load;
   logic                        grant_vld;
   logic [CH_W-1:0]             grant_idx;

   function automatic logic qual_edge(input logic x, input logic x_prev, input logic [1:0] sel);
      case (sel)
         2'd0:    return x & ~x_prev;
         2'd1:    return ~x & x_prev;
         default: return x ^ x_prev;
      endcase
   endfunction

   function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base, input int k);
      return CH_W'((int'(base) + k) % N_CH);
   endfunction

   always_comb begin
      // NOTE: every signal is given a default before any branch, so no path can infer a latch.
      start_edge = qual_edge(ref_in, ref_in_q, edge_sel);
      stop_edge  = '0;
      for (int i = 0; i < N_CH; i++) begin
         stop_edge[i] = qual_edge(sig_in[i], sig_in_q[i], edge_sel);
      end
   end

   // Per-channel interval FSM; stop edges in IDLE are ignored.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cap_vld  = '0;
      cap_ovf  = '0;
      lost_set = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (!en) begin
            state_d[i] = IDLE;
         end else if (state_q[i] == IDLE) begin
            if (start_edge) begin
               state_d[i] = COUNTING;
               cnt_d[i]   = CNT_ONE;
            end
         end else if (stop_edge[i]) begin
            cap_vld[i] = 1'b1;
            if (start_edge) begin
               cnt_d[i] = CNT_ONE;
            end else begin
               state_d[i] = IDLE;
            end
         end else if (start_edge) begin
            lost_set[i] = 1'b1;
            cnt_d[i]    = CNT_ONE;
         end else if (cnt_q[i] == CNT_MAX) begin
            cap_vld[i]  = 1'b1;
            cap_ovf[i]  = 1'b1;
            state_d[i]  = IDLE;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (!grant_vld && pend_q[rr_index(rr_ptr_q, k)]) begin
            grant_vld = 1'b1;
            grant_idx = rr_index(rr_ptr_q, k);
         end
      end
   end

   // Grant clears the slot first, so a capture into the granted channel lands instead of dropping.
   always_comb begin
      out_load    = ~out_valid_q | out_ready;
      out_valid_d = out_valid_q;
      out_ch_d    = out_ch_q;
      out_time_d  = out_time_q;
      out_ovf_d   = out_ovf_q;
      rr_ptr_d    = rr_ptr_q;
      pend_d      = pend_q;
      pend_time_d = pend_time_q;
      pend_ovf_d  = pend_ovf_q;
      drop_set    = '0;
      if (out_load) begin
         out_valid_d = grant_vld;
         if (grant_vld) begin
            out_ch_d          = grant_idx;
            out_time_d        = pend_time_q[grant_idx];
            out_ovf_d         = pend_ovf_q[grant_idx];
            pend_d[grant_idx] = 1'b0;
            rr_ptr_d          = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
         end
      end
      for (int i = 0; i < N_CH; i++) begin
         if (cap_vld[i]) begin
            if (pend_d[i]) begin
               drop_set[i] = 1'b1;
            end else begin
               pend_d[i]      = 1'b1;
               pend_time_d[i] = cnt_q[i];
               pend_ovf_d[i]  = cap_ovf[i];
            end
         end
      end
      drop_err_d = (drop_err_q & ~{N_CH{clr_err}}) | drop_set;
      lost_err_d = (lost_err_q & ~{N_CH{clr_err}}) | lost_set;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      if (rst) begin
         ref_in_q    <= 1'b0;
         sig_in_q    <= '0;
         pend_q      <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_time_q  <= '0;
         out_ovf_q   <= 1'b0;
         rr_ptr_q    <= '0;
         drop_err_q  <= '0;
         lost_err_q  <= '0;
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= IDLE;
         end
      end else begin
         ref_in_q    <= ref_in;
         sig_in_q    <= sig_in;
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         out_time_q  <= out_time_d;
         out_ovf_q   <= out_ovf_d;
         rr_ptr_q    <= rr_ptr_d;
         drop_err_q  <= drop_err_d;
         lost_err_q  <= lost_err_d;
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
         end
      end
   end

   // NOTE: count and slot data are only read when state/pend qualify them, so they carry no reset.
   always_ff @(posedge clk) begin
      cnt_q       <= cnt_d;
      pend_time_q <= pend_time_d;
      pend_ovf_q  <= pend_ovf_d;
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < N_CH; i++) begin
         busy[i] = (state_q[i] == COUNTING);
      end
   end

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out_time  = out_time_q;
   assign out_ovf   = out_ovf_q;
   assign drop_err  = drop_err_q;
   assign lost_err  = lost_err_q;

endmodule
